n2_8x8_seq: RTL

- Sequential 8x8 recursive multiplier built on one N2 approximate 4x4 core (n2_4x4).
- Splits the operands into nibbles, computes the four 4x4 sub-products over four cycles and accumulates them with exact shifted addition.
- Sits directly downstream of operand capture and consumes the 4x4 core's 8-bit output every cycle.
- Valid/ready on both input and output; one operation in flight.

---
 rtl/n2_8x8_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/n2_8x8_seq.sv
// Sequential 8x8 multiplier: one shared 4x4 core evaluated over four cycles,
// nibble sub-products accumulated with exact shifted 16-bit addition.

module n2_4x4 #(
  parameter bit APPROX = 1'b1
) (
  input  logic [3:0] p_i,
  input  logic [3:0] q_i,
  output logic [7:0] prod_o
);

  if (APPROX) begin : g_n2
    logic [3:0][3:0] pp;   // pp[i][j] = p[i] & q[j], weight 2^(i+j)
    logic [5:0]      col;

    for (genvar i = 0; i < 4; i++) begin : g_row
      for (genvar j = 0; j < 4; j++) begin : g_col
        assign pp[i][j] = p_i[i] & q_i[j];
      end
    end

    // Columns 0..5 collapse their partial products with OR, no carries
    assign col[0] = pp[0][0];
    assign col[1] = pp[0][1] | pp[1][0];
    assign col[2] = pp[0][2] | pp[1][1] | pp[2][0];
    assign col[3] = pp[0][3] | pp[1][2] | pp[2][1] | pp[3][0];
    assign col[4] = pp[1][3] | pp[2][2] | pp[3][1];
    assign col[5] = pp[2][3] | pp[3][2];

    assign prod_o = {pp[3][3] & pp[2][2], pp[3][3] & ~pp[2][2], col};
  end else begin : g_exact
    assign prod_o = p_i * q_i;
  end

endmodule

module n2_8x8_seq #(
  parameter bit APPROX = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] Y,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q;
  logic [7:0]  a_q, b_q;
  logic [1:0]  cnt_q;
  logic [15:0] acc_q, acc_d;
  logic [15:0] y_q;
  logic        out_valid_q;
  logic        in_ready_q;

  logic [3:0]  nib_p, nib_q;
  logic [3:0]  shamt;
  logic [7:0]  sub_prod;
  logic [15:0] term;

  // Core operands come only from the latched nibbles, never from a/b
  always_comb begin
    nib_p = a_q[3:0];
    nib_q = b_q[3:0];
    shamt = 4'd0;
    case (cnt_q)
      2'd0: begin nib_p = a_q[3:0]; nib_q = b_q[3:0]; shamt = 4'd0; end
      2'd1: begin nib_p = a_q[7:4]; nib_q = b_q[3:0]; shamt = 4'd4; end
      2'd2: begin nib_p = a_q[3:0]; nib_q = b_q[7:4]; shamt = 4'd4; end
      2'd3: begin nib_p = a_q[7:4]; nib_q = b_q[7:4]; shamt = 4'd8; end
      default: ;
    endcase
  end

  n2_4x4 #(.APPROX(APPROX)) u_core (
    .p_i    (nib_p),
    .q_i    (nib_q),
    .prod_o (sub_prod)
  );

  assign term  = {8'h00, sub_prod} << shamt;
  assign acc_d = acc_q + term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            y_q         <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Y         = y_q;

endmodule
